// File: rtl/out_scan_mux_if.sv
// out_scan_mux_if: core-side display write port (entry writes, bulk clear, scan freeze)
interface out_scan_mux_if #(
    parameter int DATA_W = 16,
    parameter int SLOTS  = 8,
    parameter int BANKS  = 2
);
    localparam int SW = $clog2(SLOTS);
    localparam int BW = BANKS > 1 ? $clog2(BANKS) : 1;
    logic              wr_en;
    logic [SW-1:0]     wr_slot;
    logic [BW-1:0]     wr_bank;
    logic [DATA_W-1:0] wr_data;
    logic              clr;
    logic              freeze;
    modport master (output wr_en, wr_slot, wr_bank, wr_data, clr, freeze);
    modport slave  (input  wr_en, wr_slot, wr_bank, wr_data, clr, freeze);
endinterface

// File: rtl/out_scan_mux.sv
// out_scan_mux: multi-bank 7-segment scanner with prescaled, blanked, freezable slot scan
module out_scan_mux #(
    parameter int  DATA_W      = 16,
    parameter int  SLOTS       = 8,
    parameter int  BANKS       = 2,
    parameter int  PRESCALE    = 1024,
    parameter int  BLANK       = 16,
    parameter int  LZ_SUPPRESS = 0,
    localparam int DIGITS      = DATA_W / 4,
    localparam int SW          = $clog2(SLOTS),
    localparam int PW          = $clog2(PRESCALE)
) (
    input  logic                      clock,
    input  logic                      reset,
    out_scan_mux_if.slave             wr,
    output logic [BANKS*DIGITS*8-1:0] seg,
    output logic [SLOTS-1:0]          seg_sel,
    output logic [SW-1:0]             scan_slot,
    output logic                      step_pulse
);
    logic [DATA_W-1:0]        data_q [SLOTS][BANKS];
    logic [BANKS-1:0]         valid_q [SLOTS];
    logic [PW-1:0]            pre_q;
    logic [BANKS*DIGITS*4-1:0] nib_q, nib_d;
    logic [BANKS*DIGITS-1:0]  en_q, en_d;
    logic [SLOTS-1:0]         sel_d;
    logic [3:0]               nib;
    logic                     lz;
    logic                     wrap, blank, wr_ok;

    assign wrap  = int'(pre_q) == PRESCALE - 1;
    assign blank = int'(pre_q) < BLANK;
    assign wr_ok = wr.wr_en && int'(wr.wr_slot) < SLOTS && int'(wr.wr_bank) < BANKS;
    assign sel_d = blank ? '0 : SLOTS'(1) << scan_slot;

    function automatic logic [7:0] seg7(input logic [3:0] n);
        logic [7:0] s;
        s = 8'h00;
        case (n)
            4'h0: s = 8'h3F;
            4'h1: s = 8'h06;
            4'h2: s = 8'h5B;
            4'h3: s = 8'h4F;
            4'h4: s = 8'h66;
            4'h5: s = 8'h6D;
            4'h6: s = 8'h7D;
            4'h7: s = 8'h07;
            4'h8: s = 8'h7F;
            4'h9: s = 8'h6F;
            4'hA: s = 8'h77;
            4'hB: s = 8'h7C;
            4'hC: s = 8'h39;
            4'hD: s = 8'h5E;
            4'hE: s = 8'h79;
            4'hF: s = 8'h71;
        endcase
        return s;
    endfunction

    // clear applies first so a same-edge write still lands valid
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            data_q  <= '{default: '0};
            valid_q <= '{default: '0};
        end else begin
            if (wr.clr)
                valid_q <= '{default: '0};
            if (wr_ok) begin
                data_q[wr.wr_slot][wr.wr_bank]  <= wr.wr_data;
                valid_q[wr.wr_slot][wr.wr_bank] <= 1'b1;
            end
        end

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            pre_q      <= '0;
            scan_slot  <= '0;
            step_pulse <= 1'b0;
        end else begin
            step_pulse <= !wr.freeze && wrap;
            if (!wr.freeze) begin
                pre_q <= wrap ? '0 : pre_q + 1'b1;
                if (wrap)
                    scan_slot <= int'(scan_slot) == SLOTS - 1 ? '0 : scan_slot + 1'b1;
            end
        end

    // lz tracks "every nibble from the MS end up to k is zero"
    always_comb begin
        nib_d = '0;
        en_d  = '0;
        nib   = '0;
        lz    = 1'b0;
        for (int b = 0; b < BANKS; b++) begin
            lz = 1'b1;
            for (int k = 0; k < DIGITS; k++) begin
                nib = data_q[scan_slot][b][DATA_W-1-4*k -: 4];
                lz  = lz && nib == 4'h0;
                nib_d[(b*DIGITS+k)*4 +: 4] = nib;
                en_d[b*DIGITS+k] = !blank && valid_q[scan_slot][b]
                                   && !(LZ_SUPPRESS != 0 && lz && k < DIGITS - 1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            seg_sel <= '0;
            nib_q   <= '0;
            en_q    <= '0;
        end else begin
            seg_sel <= sel_d;
            nib_q   <= nib_d;
            en_q    <= en_d;
        end

    always_comb begin
        seg = '0;
        for (int i = 0; i < BANKS*DIGITS; i++)
            seg[i*8 +: 8] = en_q[i] ? seg7(nib_q[i*4 +: 4]) : 8'h00;
    end
endmodule

// File: tb/tb_out_scan_mux.sv
// tb_out_scan_mux: directed vectors, corner sequences and a random run against a reference model
module tb_out_scan_mux;
    localparam int PS = 4, BL = 1, SL = 8;
    localparam logic [7:0] SEG7 [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                          8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    out_scan_mux_if #(.DATA_W(16), .SLOTS(8), .BANKS(2)) w0();
    out_scan_mux_if #(.DATA_W(8),  .SLOTS(5), .BANKS(1)) w1();

    logic [63:0] seg;
    logic [7:0]  seg_sel;
    logic [2:0]  scan_slot;
    logic        step_pulse;
    logic [15:0] seg1;
    logic [4:0]  sel1;
    logic [2:0]  slot1;
    logic        step1;

    out_scan_mux #(.DATA_W(16), .SLOTS(8), .BANKS(2), .PRESCALE(4), .BLANK(1), .LZ_SUPPRESS(1)) dut (
        .clock(clock), .reset(reset), .wr(w0), .seg(seg), .seg_sel(seg_sel),
        .scan_slot(scan_slot), .step_pulse(step_pulse));

    out_scan_mux #(.DATA_W(8), .SLOTS(5), .BANKS(1), .PRESCALE(4), .BLANK(0), .LZ_SUPPRESS(0)) dut1 (
        .clock(clock), .reset(reset), .wr(w1), .seg(seg1), .seg_sel(sel1),
        .scan_slot(slot1), .step_pulse(step1));

    int checks = 0, errors = 0;
    bit chk_on = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference model: stored words, flags and a scan position, outputs derived from the rules
    logic [15:0] m_data [8][2];
    bit          m_valid [8][2];
    int          m_pre, m_slot;
    logic [63:0] e_seg;
    logic [7:0]  e_sel;
    logic        e_step;
    int          top;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            foreach (m_data[s, b]) begin
                m_data[s][b]  = '0;
                m_valid[s][b] = 0;
            end
            m_pre = 0; m_slot = 0; e_seg = '0; e_sel = '0; e_step = 0;
        end else begin
            e_sel = m_pre < BL ? 8'h00 : 8'(1 << m_slot);
            e_seg = '0;
            for (int b = 0; b < 2; b++)
                for (int k = 0; k < 4; k++) begin
                    top = int'(m_data[m_slot][b]) >> (4 * (3 - k));
                    if (m_pre >= BL && m_valid[m_slot][b] && (k == 3 || top != 0))
                        e_seg[(b*4+k)*8 +: 8] = SEG7[top & 15];
                end
            if (w0.clr)
                foreach (m_valid[s, b]) m_valid[s][b] = 0;
            if (w0.wr_en) begin
                m_data[w0.wr_slot][w0.wr_bank]  = w0.wr_data;
                m_valid[w0.wr_slot][w0.wr_bank] = 1;
            end
            e_step = !w0.freeze && m_pre == PS - 1;
            if (!w0.freeze) begin
                if (m_pre == PS - 1) m_slot = (m_slot + 1) % SL;
                m_pre = (m_pre + 1) % PS;
            end
        end
    end

    always @(negedge clock)
        if (chk_on) begin
            check("seg", seg, e_seg);
            check("seg_sel", 64'(seg_sel), 64'(e_sel));
            check("scan_slot", 64'(scan_slot), 64'(m_slot));
            check("step_pulse", 64'(step_pulse), 64'(e_step));
        end

    task automatic wr0(input int s, input int b, input logic [15:0] d, input logic c);
        w0.wr_en = 1; w0.wr_slot = 3'(s); w0.wr_bank = 1'(b); w0.wr_data = d; w0.clr = c;
        @(negedge clock);
        w0.wr_en = 0; w0.clr = 0;
    endtask

    task automatic wr1(input int s, input int b, input logic [7:0] d);
        w1.wr_en = 1; w1.wr_slot = 3'(s); w1.wr_bank = 1'(b); w1.wr_data = d;
        @(negedge clock);
        w1.wr_en = 0;
    endtask

    task automatic wait_sel(input logic [7:0] s);
        int n = 0;
        while (seg_sel !== s && n < 80) begin @(negedge clock); n++; end
        check("wait_seg_sel", 64'(seg_sel), 64'(s));
    endtask

    task automatic wait_sel1(input logic [4:0] s);
        int n = 0;
        while (sel1 !== s && n < 80) begin @(negedge clock); n++; end
        check("wait_sel1", 64'(sel1), 64'(s));
    endtask

    task automatic wait_slot5_lit;
        int n = 0;
        while (!(scan_slot == 3'd5 && seg_sel == 8'h20) && n < 80) begin @(negedge clock); n++; end
        check("wait_slot5", 64'(scan_slot), 64'd5);
    endtask

    typedef struct { int slot; int bank; logic [15:0] data; logic [31:0] exp; } vec_t;
    vec_t vecs [6];

    initial begin
        int steps, last, gap_bad, post_bad, held, zeros, n;
        bit wrap, prev_step;
        logic [2:0] prev_slot;
        logic [15:0] d;
        vecs[0] = '{3, 0, 16'h12AB, 32'h7C775B06};
        vecs[1] = '{5, 1, 16'h0007, 32'h07000000};
        vecs[2] = '{0, 1, 16'h0000, 32'h3F000000};
        vecs[3] = '{7, 0, 16'h0F30, 32'h3F4F7100};
        vecs[4] = '{1, 1, 16'hE0D9, 32'h6F5E3F79};
        vecs[5] = '{6, 0, 16'h00C8, 32'h7F390000};
        w0.wr_en = 0; w0.wr_slot = '0; w0.wr_bank = '0; w0.wr_data = '0; w0.clr = 0; w0.freeze = 0;
        w1.wr_en = 0; w1.wr_slot = '0; w1.wr_bank = '0; w1.wr_data = '0; w1.clr = 0; w1.freeze = 0;
        reset = 1;
        repeat (3) @(negedge clock);
        reset = 0;
        chk_on = 1;
        check("rst_seg", seg, 64'h0);
        check("rst_sel", 64'(seg_sel), 64'h0);
        check("rst_slot", 64'(scan_slot), 64'h0);
        check("rst_step", 64'(step_pulse), 64'h0);

        // one entry per slot, other bank of the same slot never written
        foreach (vecs[i]) begin
            wr0(vecs[i].slot, vecs[i].bank, vecs[i].data, 1'b0);
            wait_sel(8'(1 << vecs[i].slot));
            check("vec_bank", 64'(seg[vecs[i].bank*32 +: 32]), 64'(vecs[i].exp));
            check("vec_other", 64'(seg[(1-vecs[i].bank)*32 +: 32]), 64'h0);
        end

        steps = 0; last = -1; gap_bad = 0; post_bad = 0; wrap = 0; prev_step = 0; prev_slot = scan_slot;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (prev_step && seg_sel != 8'h00) post_bad++;
            if (step_pulse) begin
                if (last >= 0 && i - last != 4) gap_bad++;
                last = i;
                steps++;
            end
            if (prev_slot == 3'd7 && scan_slot == 3'd0) wrap = 1;
            prev_step = step_pulse;
            prev_slot = scan_slot;
        end
        check("run_steps", 64'(steps), 64'd10);
        check("run_gap", 64'(gap_bad), 64'd0);
        check("run_wrap", 64'(wrap), 64'd1);
        check("run_blank_after_step", 64'(post_bad), 64'd0);

        wait_slot5_lit();
        w0.freeze = 1;
        held = 0;
        repeat (10) begin
            @(negedge clock);
            if (scan_slot == 3'd5 && seg_sel == 8'h20 && !step_pulse) held++;
        end
        check("freeze_hold", 64'(held), 64'd10);
        w0.freeze = 0;
        n = 0;
        while (!step_pulse && n < 8) begin @(negedge clock); n++; end
        check("freeze_resume", 64'(step_pulse), 64'd1);

        wr0(5, 1, 16'h0007, 1'b1);
        wait_sel(8'h20);
        check("clr_wr_slot5", seg, 64'h07000000_00000000);
        wait_sel(8'h08);
        check("clr_slot3", seg, 64'h0);
        wait_sel(8'h01);
        check("clr_slot0", seg, 64'h0);

        wait_slot5_lit();
        w0.freeze = 1; w0.clr = 1;
        @(negedge clock);
        w0.clr = 0;
        check("clr_late_lit", seg, 64'h07000000_00000000);
        @(negedge clock);
        check("clr_late_blank", seg, 64'h0);
        check("clr_late_sel", 64'(seg_sel), 64'h20);
        w0.freeze = 0;

        wr1(3, 1, 8'h5A);
        wr1(6, 0, 8'h77);
        wait_sel1(5'b01000);
        check("u1_bank_ignored", 64'(seg1), 64'h0);
        wait_sel1(5'b00010);
        check("u1_slot_ignored", 64'(seg1), 64'h0);
        wr1(3, 0, 8'h42);
        wait_sel1(5'b01000);
        check("u1_write", 64'(seg1), 64'h5B66);
        zeros = 0; wrap = 0; prev_slot = slot1;
        repeat (40) begin
            @(negedge clock);
            if (sel1 == 5'b0) zeros++;
            if (prev_slot == 3'd4 && slot1 == 3'd0) wrap = 1;
            prev_slot = slot1;
        end
        check("u1_no_blank", 64'(zeros), 64'd0);
        check("u1_wrap", 64'(wrap), 64'd1);

        wait_sel(8'h04);
        #2 reset = 1;
        #1;
        check("mid_rst_sel", 64'(seg_sel), 64'h0);
        check("mid_rst_seg", seg, 64'h0);
        check("mid_rst_slot", 64'(scan_slot), 64'h0);
        check("mid_rst_step", 64'(step_pulse), 64'h0);
        @(negedge clock);
        reset = 0;

        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 4; k++)
                d[k*4 +: 4] = $urandom_range(0, 2) == 0 ? 4'h0 : 4'($urandom_range(0, 15));
            w0.wr_en   = 1'($urandom_range(0, 1));
            w0.wr_slot = 3'($urandom_range(0, 7));
            w0.wr_bank = 1'($urandom_range(0, 1));
            w0.wr_data = d;
            w0.clr     = $urandom_range(0, 29) == 0;
            w0.freeze  = $urandom_range(0, 7) == 0;
            @(negedge clock);
        end
        w0.wr_en = 0; w0.clr = 0; w0.freeze = 0;
        @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
